// File: rtl/key_press_conditioner.sv
// Push-button conditioner: 2-flop sync, per-key debounce, and a one-shot press FSM
// that emits a single one-hot pulse per accepted press, then waits for all keys released.
module key_press_conditioner #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_raw,
  output logic [KEY_WIDTH-1:0] key_pulse,
  output logic                 key_held,
  output logic [KEY_WIDTH-1:0] key_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [KEY_WIDTH-1:0] RELEASED = {KEY_WIDTH{KEYS_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  logic [KEY_WIDTH-1:0] sync1_q, sync2_q, sync_norm;
  logic [KEY_WIDTH-1:0] level_q, level_d;
  logic [CNT_W-1:0]     cnt_q [KEY_WIDTH];
  logic [CNT_W-1:0]     cnt_d [KEY_WIDTH];
  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] sel_q, sel_d, lowest_bit;
  logic [KEY_WIDTH-1:0] pulse_q, pulse_d;
  logic                 held_q, held_d;

  // XOR with the released pattern maps both polarities onto pressed = 1.
  assign sync_norm = sync2_q ^ RELEASED;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_norm[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync_norm[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < KEY_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign lowest_bit = level_q & (~level_q + 1'b1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|level_q) begin
          sel_d   = lowest_bit;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: state_d = ST_HELD;
      ST_HELD: begin
        if (level_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    pulse_d = (state_d == ST_PULSE) ? sel_d : '0;
    held_d  = (state_d == ST_HELD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      pulse_q <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign key_pulse = pulse_q;
  assign key_held  = held_q;
  assign key_level = level_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner with DEBOUNCE_CYCLES=4 and active-low keys, checked
// every cycle against a sample-history reference model plus scenario-specific timing checks.
module tb_key_press_conditioner;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] key_pulse;
  logic       key_held;
  logic [3:0] key_level;

  int total = 0;
  int bad   = 0;

  key_press_conditioner #(
    .KEY_WIDTH(4),
    .DEBOUNCE_CYCLES(DC),
    .KEYS_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_raw(key_raw),
    .key_pulse(key_pulse),
    .key_held(key_held),
    .key_level(key_level)
  );

  initial forever #5 clock = ~clock;

  // Reference model: a key's level flips once the last DC synchronised samples all
  // disagree with it; a press is owed whenever idle with any level set.
  logic [3:0] hist[$];
  logic [3:0] m_level = '0;
  logic [3:0] m_pulse = '0;
  logic       m_held  = 1'b0;

  initial begin
    logic [3:0] old_lvl;
    logic [3:0] new_lvl;
    bit         all_diff;
    repeat (DC + 2) hist.push_front(4'h0);
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        hist = {};
        repeat (DC + 2) hist.push_front(4'h0);
        m_level = '0;
        m_pulse = '0;
        m_held  = 1'b0;
      end else begin
        old_lvl = m_level;
        new_lvl = m_level;
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= DC; k++) begin
            if (hist[k][i] == old_lvl[i]) all_diff = 1'b0;
          end
          if (all_diff) new_lvl[i] = ~old_lvl[i];
        end
        if (m_pulse != 0) begin
          m_pulse = '0;
          m_held  = 1'b1;
        end else if (m_held) begin
          if (old_lvl == 0) m_held = 1'b0;
        end else if (old_lvl != 0) begin
          m_pulse = old_lvl & (~old_lvl + 4'd1);
        end
        m_level = new_lvl;
        hist.push_front(~key_raw);
        void'(hist.pop_back());
      end
    end
  end

  task automatic test_reset();
    reset   = 1'b0;
    key_raw = 4'hF;
    repeat (3) @(negedge clock);
    total++;
    if ({key_pulse, key_held, key_level} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got p=%b h=%b l=%b exp all 0", key_pulse, key_held, key_level);
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL reset_idle k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulse_cyc = -1;
    int npulse = 0;
    key_raw = 4'b1110;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL clean_model k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
      if (key_pulse != 0) begin
        npulse++;
        if (pulse_cyc < 0) pulse_cyc = k;
      end
      if (k == 5 || k == 6) begin
        total++;
        if (key_level !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
          bad++;
          $display("FAIL clean_level k=%0d got %b", k, key_level);
        end
      end
      if (k == 7) begin
        total++;
        if (key_pulse !== 4'b0001) begin
          bad++;
          $display("FAIL clean_pulse_value got %b exp 0001", key_pulse);
        end
      end
      if (k == 8) begin
        total++;
        if (key_held !== 1'b1 || key_pulse !== 4'b0000) begin
          bad++;
          $display("FAIL clean_held got h=%b p=%b exp h=1 p=0000", key_held, key_pulse);
        end
      end
    end
    total++;
    if (pulse_cyc != 7 || npulse != 1) begin
      bad++;
      $display("FAIL clean_pulse_timing got cycle=%0d count=%0d exp cycle=7 count=1", pulse_cyc, npulse);
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL release_model k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
      if (k == 6 || k == 7) begin
        total++;
        if (key_held !== (k == 6)) begin
          bad++;
          $display("FAIL release_held k=%0d got %b", k, key_held);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int ntoggle = 2 * $urandom_range(3, 6);
    int npulse = 0;
    int pulse_cyc = -1;
    key_raw = 4'hF;
    for (int t = 0; t < ntoggle; t++) begin
      int len = $urandom_range(1, 3);
      key_raw[1] = ~key_raw[1];
      for (int k = 0; k < len; k++) begin
        @(negedge clock);
        total++;
        if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level} || key_pulse !== 4'b0) begin
          bad++;
          $display("FAIL bounce_toggle t=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                   t, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
        end
      end
    end
    key_raw = 4'b1101;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL bounce_model k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
      if (key_pulse != 0) begin
        npulse++;
        pulse_cyc = k;
        total++;
        if (key_pulse !== 4'b0010) begin
          bad++;
          $display("FAIL bounce_pulse_value got %b exp 0010", key_pulse);
        end
      end
    end
    total++;
    if (npulse != 1 || pulse_cyc != 7) begin
      bad++;
      $display("FAIL bounce_pulse_timing got count=%0d cycle=%0d exp count=1 cycle=7", npulse, pulse_cyc);
    end
    key_raw = 4'hF;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_simultaneous();
    int npulse = 0;
    key_raw = 4'b0101;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL simul_model k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
      if (key_pulse != 0) begin
        npulse++;
        total++;
        if (key_pulse !== 4'b0010) begin
          bad++;
          $display("FAIL simul_pulse_value got %b exp 0010", key_pulse);
        end
      end
    end
    total++;
    if (npulse != 1 || key_level !== 4'b1010) begin
      bad++;
      $display("FAIL simul_summary got count=%0d level=%b exp count=1 level=1010", npulse, key_level);
    end
    key_raw = 4'hF;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_overlap();
    logic [3:0] phases [6] = '{4'b1110, 4'b1010, 4'b1011, 4'b1111, 4'b1011, 4'b1111};
    logic [3:0] seen_val [$];
    int         seen_ph [$];
    for (int p = 0; p < 6; p++) begin
      key_raw = phases[p];
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock);
        total++;
        if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
          bad++;
          $display("FAIL overlap_model ph=%0d k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                   p, k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
        end
        if (key_pulse != 0) begin
          seen_val.push_back(key_pulse);
          seen_ph.push_back(p);
        end
      end
    end
    total++;
    if (seen_val.size() != 2) begin
      bad++;
      $display("FAIL overlap_count got %0d exp 2", seen_val.size());
    end else if (seen_val[0] !== 4'b0001 || seen_ph[0] != 0 || seen_val[1] !== 4'b0100 || seen_ph[1] != 4) begin
      bad++;
      $display("FAIL overlap_order got %b@%0d %b@%0d exp 0001@0 0100@4",
               seen_val[0], seen_ph[0], seen_val[1], seen_ph[1]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int npulse = 0;
    int pulse_cyc = -1;
    key_raw = 4'b1110;
    for (int k = 0; k < 20 && key_pulse == 0; k++) @(negedge clock);
    total++;
    if (key_pulse === 4'b0) begin
      bad++;
      $display("FAIL rst_wait_pulse got timeout exp pulse within 20 cycles");
    end
    reset = 1'b0;
    #1;
    total++;
    if ({key_pulse, key_held, key_level} !== 9'd0) begin
      bad++;
      $display("FAIL rst_async_clear got p=%b h=%b l=%b exp all 0", key_pulse, key_held, key_level);
    end
    @(negedge clock);
    key_raw = 4'hF;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level} || key_pulse !== 4'b0) begin
        bad++;
        $display("FAIL rst_no_pulse k=%0d got p=%b h=%b l=%b", k, key_pulse, key_held, key_level);
      end
    end
    // Key held across reset release must still be accepted.
    key_raw = 4'b0111;
    reset   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL rst_held_model k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
      if (key_pulse != 0) begin
        npulse++;
        pulse_cyc = k;
      end
    end
    total++;
    if (npulse != 1 || pulse_cyc != 7) begin
      bad++;
      $display("FAIL rst_held_pulse got count=%0d cycle=%0d exp count=1 cycle=7", npulse, pulse_cyc);
    end
    key_raw = 4'hF;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_glitch();
    int len = $urandom_range(1, DC - 1);
    for (int k = 1; k <= len + 12; k++) begin
      key_raw = (k <= len) ? 4'b1011 : 4'b1111;
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level} ||
          key_level !== 4'b0 || key_pulse !== 4'b0) begin
        bad++;
        $display("FAIL glitch k=%0d len=%0d got p=%b h=%b l=%b exp all 0", k, len, key_pulse, key_held, key_level);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      int len = $urandom_range(1, 10);
      key_raw = 4'($urandom_range(0, 15));
      for (int k = 0; k < len; k++) begin
        @(negedge clock);
        total++;
        if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
          bad++;
          $display("FAIL random_model seg=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                   s, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
        end
      end
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      total++;
      if ({key_pulse, key_held, key_level} !== {m_pulse, m_held, m_level}) begin
        bad++;
        $display("FAIL random_drain k=%0d got p=%b h=%b l=%b exp p=%b h=%b l=%b",
                 k, key_pulse, key_held, key_level, m_pulse, m_held, m_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_overlap();
    test_reset_mid_pulse();
    test_glitch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
